// File: rtl/minterm_lut_pkg.sv
// rtl/minterm_lut_pkg.sv - shared types and defaults for the minterm lookup table
package minterm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } sweep_state_t;

  localparam int N_IN_DEFAULT = 5;

  // Minterms 0,2,3,4,8,21,22,29,31 set
  localparam logic [31:0] RESET_TABLE_DEFAULT = 32'hA060_011D;

endpackage

// File: rtl/minterm_lut_if.sv
// rtl/minterm_lut_if.sv - write, lookup and sweep signal bundle for minterm_lut
interface minterm_lut_if #(
  parameter int N_IN = 5
) ();

  logic            wr_en;
  logic [N_IN-1:0] wr_addr;
  logic            wr_data;
  logic            clr;
  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic            out_valid;
  logic            out_f;
  logic            sweep_start;
  logic            sweep_busy;
  logic            sweep_done;
  logic [N_IN:0]   minterm_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, clr, in_valid, in_vec, sweep_start,
    input  out_valid, out_f, sweep_busy, sweep_done, minterm_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr, in_valid, in_vec, sweep_start,
    output out_valid, out_f, sweep_busy, sweep_done, minterm_cnt
  );

endinterface

// File: rtl/minterm_lut_sweep.sv
// rtl/minterm_lut_sweep.sv - sweep engine that counts the set minterms of the table
module minterm_sweep
  import minterm_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2**N_IN-1:0] lut,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [N_IN:0]      cnt
);

  sweep_state_t    state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN:0]   acc_q, acc_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic [N_IN:0]   acc_plus;

  // Running sum including the entry scanned this cycle (its current value)
  assign acc_plus = acc_q + (N_IN+1)'(lut[idx_q]);

  // State, index, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; result is latched on the edge entering DONE so it is valid with the pulse
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      SCAN: begin
        acc_d = acc_plus;
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = DONE;
          cnt_d   = acc_plus;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == SCAN);
  assign done = (state_q == DONE);
  assign cnt  = cnt_q;

endmodule

// File: rtl/minterm_lut.sv
// rtl/minterm_lut.sv - reloadable truth-table logic function; sweep built when MINTERM_SWEEP_EN is defined
module minterm_lut
  import minterm_pkg::*;
#(
  parameter int                 N_IN        = N_IN_DEFAULT,
  parameter logic [2**N_IN-1:0] RESET_TABLE = RESET_TABLE_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  minterm_lut_if.slave bus
);

  logic [2**N_IN-1:0] lut_q;
  logic               out_valid_q;
  logic               out_f_q;

  // Truth table: clear wins over a same-cycle single-bit write
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_q <= RESET_TABLE;
    end else if (bus.clr) begin
      lut_q <= '0;
    end else if (bus.wr_en) begin
      lut_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Lookup stage reads the pre-update table, so same-cycle writes return the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_f_q     <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_f_q <= lut_q[bus.in_vec];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_f     = out_f_q;

`ifdef MINTERM_SWEEP_EN
  minterm_sweep #(
    .N_IN(N_IN)
  ) u_sweep (
    .clk  (clk),
    .rst  (rst),
    .lut  (lut_q),
    .start(bus.sweep_start),
    .busy (bus.sweep_busy),
    .done (bus.sweep_done),
    .cnt  (bus.minterm_cnt)
  );
`else
  logic unused_sweep_start;
  assign unused_sweep_start = bus.sweep_start;
  assign bus.sweep_busy     = 1'b0;
  assign bus.sweep_done     = 1'b0;
  assign bus.minterm_cnt    = '0;
`endif

endmodule

// File: tb/tb_minterm_lut.sv
// tb/tb_minterm_lut.sv - scoreboard bench for minterm_lut with randomized traffic
module tb_minterm_lut;

  localparam int          N_IN    = 5;
  localparam int          DEPTH   = 32;
  localparam logic [31:0] RST_TBL = 32'hA060_011D;
`ifdef MINTERM_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  minterm_lut_if #(.N_IN(N_IN)) bus ();

  minterm_lut #(
    .N_IN       (N_IN),
    .RESET_TABLE(RST_TBL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference: the table as an array of bits plus a per-cycle view of the scan position
  bit model[DEPTH];
  int scan_pos = -1;   // -1 idle, 0..31 next entry to scan, 32 the done cycle
  int acc      = 0;
  bit exp_busy = 1'b0;
  bit exp_done = 1'b0;
  bit lut_q[$];
  int cnt_q[$];
  int hold     = 0;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_reset();
    logic [31:0] t;
    t = RST_TBL;
    for (int i = 0; i < DEPTH; i++) model[i] = t[i];
  endtask

  // One clock cycle of stimulus; the model advances exactly as the table is seen that cycle
  task automatic step(input bit r, input bit w, input int wa, input bit wd, input bit c,
                      input bit iv, input int vec, input bit st);
    int prev;
    @(negedge clk);
    rst             = r;
    bus.wr_en       = w;
    bus.wr_addr     = wa[N_IN-1:0];
    bus.wr_data     = wd;
    bus.clr         = c;
    bus.in_valid    = iv;
    bus.in_vec      = vec[N_IN-1:0];
    bus.sweep_start = st;
    if (r) begin
      load_reset();
      scan_pos = -1;
      acc      = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      prev = scan_pos;
      if (SWEEP) begin
        if (prev >= 0 && prev < DEPTH) begin
          acc += int'(model[prev]);
          scan_pos++;
          if (scan_pos == DEPTH) cnt_q.push_back(acc);
        end else if (prev == DEPTH) begin
          scan_pos = -1;
        end
        if (prev == -1 && st) begin
          acc      = 0;
          scan_pos = 0;
        end
      end
      exp_busy = (scan_pos >= 0 && scan_pos < DEPTH);
      exp_done = (scan_pos == DEPTH);
      if (iv) lut_q.push_back(model[vec % DEPTH]);
      if (c) begin
        for (int i = 0; i < DEPTH; i++) model[i] = 1'b0;
      end else if (w) begin
        model[wa % DEPTH] = wd;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic look(input int vec);
    step(0, 0, 0, 0, 0, 1, vec, 0);
  endtask

  task automatic sweep();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(40);
  endtask

  // Monitor: samples just after each rising edge, pops expectations when the DUT presents results
  always @(posedge clk) begin
    bit e;
    #1;
    if (rst) begin
      lut_q.delete();
      cnt_q.delete();
      hold = 0;
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_out_f", int'(bus.out_f), 0);
    end else if (bus.out_valid) begin
      if (lut_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = lut_q.pop_front();
        chk("out_f", int'(bus.out_f), int'(e));
      end
    end
    chk("sweep_busy", int'(bus.sweep_busy), int'(exp_busy));
    chk("sweep_done", int'(bus.sweep_done), int'(exp_done));
    if (!rst && bus.sweep_done) begin
      if (cnt_q.size() == 0) chk("unexpected_sweep_done", 1, 0);
      else hold = cnt_q.pop_front();
    end
    chk("minterm_cnt", int'(bus.minterm_cnt), hold);
  end

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = 0; bus.clr = 0;
    bus.in_valid = 0; bus.in_vec = '0; bus.sweep_start = 0;
    load_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    look(21); look(1); look(31); idle(2);
    sweep();

    step(0, 1, 1, 1, 0, 1, 1, 0);   // write and lookup of entry 1 together
    look(1); idle(1);
    sweep();

    step(0, 1, 5, 1, 1, 0, 0, 0);   // clr and write together
    look(0); look(5); idle(1);
    sweep();

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(9);
    step(1, 0, 0, 0, 0, 1, 3, 0);   // reset on the 10th busy cycle
    look(21);
    idle(40);

    step(0, 0, 0, 0, 0, 0, 0, 1);   // writes while scanning
    for (int i = 0; i < 34; i++)
      step(0, 1, $urandom_range(0, DEPTH-1), 1'($urandom), 0, 1, $urandom_range(0, DEPTH-1), 1'($urandom));
    idle(3);

    for (int n = 0; n < 1500; n++) begin
      step(($urandom % 150) == 0,
           ($urandom % 5) == 0, $urandom_range(0, DEPTH-1), 1'($urandom),
           ($urandom % 60) == 0,
           ($urandom % 10) < 7, $urandom_range(0, DEPTH-1),
           ($urandom % 20) == 0);
    end
    idle(40);

    chk("lookup_queue_drained", lut_q.size(), 0);
    chk("count_queue_drained", cnt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
